// File: rtl/time_set_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// time_set_ctrl_pkg
// Shared definitions for the time-entry controller: field-select codes, BCD
// range limits, the controller state encoding and the state -> field decode.
// -----------------------------------------------------------------------------
package time_set_ctrl_pkg;

    // Field-select codes driven to the display and to the validator.
    localparam logic [2:0] FIELD_HOUR = 3'b011;
    localparam logic [2:0] FIELD_MIN  = 3'b110;
    localparam logic [2:0] FIELD_SEC  = 3'b101;
    localparam logic [2:0] FIELD_NONE = 3'b111;

    // Largest legal packed-BCD values per field.
    localparam logic [7:0] MAX_HOUR_BCD   = 8'h23;
    localparam logic [7:0] MAX_MINSEC_BCD = 8'h59;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOUR   = 3'd1,
        ST_MIN    = 3'd2,
        ST_SEC    = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    function automatic logic [2:0] field_of_state(input state_t s);
        case (s)
            ST_HOUR: return FIELD_HOUR;
            ST_MIN:  return FIELD_MIN;
            ST_SEC:  return FIELD_SEC;
            default: return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/time_field_validator.sv
// -----------------------------------------------------------------------------
// time_field_validator
// Combinational check of a two-digit packed-BCD entry against the field that
// is currently being edited.
//   time_in   : packed BCD, tens digit in [7:4]
//   field_sel : FIELD_HOUR / FIELD_MIN / FIELD_SEC / FIELD_NONE
//   valid     : both digits are 0-9 and the value is within the field range;
//               always 0 for FIELD_NONE
// -----------------------------------------------------------------------------
module time_field_validator
    import time_set_ctrl_pkg::*;
(
    input  logic [7:0] time_in,
    input  logic [2:0] field_sel,
    output logic       valid
);

    logic bcd_ok;

    assign bcd_ok = (time_in[7:4] <= 4'd9) && (time_in[3:0] <= 4'd9);

    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        valid = 1'b0;
        case (field_sel)
            FIELD_HOUR: valid = bcd_ok && (time_in <= MAX_HOUR_BCD);
            FIELD_MIN,
            FIELD_SEC:  valid = bcd_ok && (time_in <= MAX_MINSEC_BCD);
            default:    valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Sequences entry of a BCD time (hour, minute, second) for the running clock
// or the alarm, validates each field, stages accepted values and issues one
// write pulse to the selected register bank when all three are accepted.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   set_req, target_sel  start a session; target 0 = clock, 1 = alarm
//   enter, cancel        accept current time_in / abort session
//   time_in[7:0]         packed BCD entry
//   busy                 session in progress (state != IDLE)
//   field_sel[2:0]       field being edited (111 = none)
//   err                  one-cycle pulse on a rejected enter
//   wr_en, wr_alarm      one-cycle commit pulse and its target
//   hh_out/mm_out/ss_out staged BCD values
//   timeout              one-cycle pulse on session expiry
//
// Build option: define TIME_SET_AUTO_TIMEOUT_EN to abandon a session after
// TIMEOUT_CYCLES idle cycles in a field state; otherwise timeout is tied low.
// -----------------------------------------------------------------------------
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TW             = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_req,
    input  logic       target_sel,
    input  logic       enter,
    input  logic       cancel,
    input  logic [7:0] time_in,
    output logic       busy,
    output logic [2:0] field_sel,
    output logic       err,
    output logic       wr_en,
    output logic       wr_alarm,
    output logic [7:0] hh_out,
    output logic [7:0] mm_out,
    output logic [7:0] ss_out,
    output logic       timeout
);

    // Catch a counter too narrow for the configured timeout at elaboration.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << TW)) begin : g_bad_cfg
        $error("time_set_ctrl: TIMEOUT_CYCLES does not fit in TW bits");
    end

    state_t     state_q, state_d;
    logic       err_d, timeout_d, wr_alarm_d;
    logic [7:0] hh_d, mm_d, ss_d;
    logic       field_valid;
    logic       expire;

    assign field_sel = field_of_state(state_q);
    assign busy      = (state_q != ST_IDLE);

    time_field_validator u_validator (
        .time_in   (time_in),
        .field_sel (field_sel),
        .valid     (field_valid)
    );

`ifdef TIME_SET_AUTO_TIMEOUT_EN
    logic [TW-1:0] cnt_q;
    logic          in_field;

    assign in_field = (state_q == ST_HOUR) || (state_q == ST_MIN) || (state_q == ST_SEC);
    // enter and cancel are handled ahead of expiry in the next-state logic.
    assign expire   = in_field && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Restart on any state change, on every enter and outside field states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!in_field || enter || (state_d != state_q)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        timeout_d  = 1'b0;
        wr_alarm_d = wr_alarm;
        hh_d       = hh_out;
        mm_d       = mm_out;
        ss_d       = ss_out;
        case (state_q)
            ST_IDLE: begin
                if (set_req) begin
                    state_d    = ST_HOUR;
                    wr_alarm_d = target_sel;
                end
            end
            ST_HOUR, ST_MIN, ST_SEC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (enter) begin
                    if (field_valid) begin
                        case (state_q)
                            ST_HOUR: begin hh_d = time_in; state_d = ST_MIN;    end
                            ST_MIN:  begin mm_d = time_in; state_d = ST_SEC;    end
                            default: begin ss_d = time_in; state_d = ST_COMMIT; end
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;  // COMMIT lasts one cycle
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            err      <= 1'b0;
            wr_en    <= 1'b0;
            wr_alarm <= 1'b0;
            timeout  <= 1'b0;
            hh_out   <= 8'h00;
            mm_out   <= 8'h00;
            ss_out   <= 8'h00;
        end else begin
            state_q  <= state_d;
            err      <= err_d;
            wr_en    <= (state_d == ST_COMMIT);  // high exactly while in COMMIT
            wr_alarm <= wr_alarm_d;
            timeout  <= timeout_d;
            hh_out   <= hh_d;
            mm_out   <= mm_d;
            ss_out   <= ss_d;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Self-checking bench for time_set_ctrl: a table of one-cycle vectors run
// through a scoreboard queue, plus hand-written reset and timeout sequences.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       set_req, target_sel, enter, cancel;
    logic [7:0] time_in;
    logic       busy, err, wr_en, wr_alarm, timeout;
    logic [2:0] field_sel;
    logic [7:0] hh_out, mm_out, ss_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       set_req;
        logic       target_sel;
        logic       enter;
        logic       cancel;
        logic [7:0] time_in;
        logic [2:0] field_sel;
        logic       busy;
        logic       err;
        logic       wr_en;
        logic       wr_alarm;
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    time_set_ctrl #(.TIMEOUT_CYCLES(8), .TW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_req    (set_req),
        .target_sel (target_sel),
        .enter      (enter),
        .cancel     (cancel),
        .time_in    (time_in),
        .busy       (busy),
        .field_sel  (field_sel),
        .err        (err),
        .wr_en      (wr_en),
        .wr_alarm   (wr_alarm),
        .hh_out     (hh_out),
        .mm_out     (mm_out),
        .ss_out     (ss_out),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample 1 unit after
    // the next rising edge.
    task automatic drive(input logic s, input logic ts, input logic e,
                         input logic c, input logic [7:0] t);
        @(negedge clk);
        set_req = s; target_sel = ts; enter = e; cancel = c; time_in = t;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic s, ts, e, c, input logic [7:0] t,
                                input logic [2:0] f, input logic b, er, w, a,
                                input logic [7:0] h, m, sc);
        vec_t v;
        v.set_req = s; v.target_sel = ts; v.enter = e; v.cancel = c; v.time_in = t;
        v.field_sel = f; v.busy = b; v.err = er; v.wr_en = w; v.wr_alarm = a;
        v.hh = h; v.mm = m; v.ss = sc;
        return v;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " field_sel"}, 32'(field_sel), 32'h7);
        check({tag, " busy"},      32'(busy),      32'h0);
        check({tag, " err"},       32'(err),       32'h0);
        check({tag, " wr_en"},     32'(wr_en),     32'h0);
        check({tag, " wr_alarm"},  32'(wr_alarm),  32'h0);
        check({tag, " timeout"},   32'(timeout),   32'h0);
        check({tag, " hh"},        32'(hh_out),    32'h0);
        check({tag, " mm"},        32'(mm_out),    32'h0);
        check({tag, " ss"},        32'(ss_out),    32'h0);
    endtask

    initial begin
        vec_t e;

        //            s  ts e  c  time    field   b  er w  a  hh     mm     ss
        // Full clock entry
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 3'b011, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(0, 0, 1, 0, 8'h12, 3'b110, 1, 0, 0, 0, 8'h12, 8'h00, 8'h00));
        vecs.push_back(mk(0, 0, 1, 0, 8'h34, 3'b101, 1, 0, 0, 0, 8'h12, 8'h34, 8'h00));
        vecs.push_back(mk(0, 0, 1, 0, 8'h56, 3'b111, 1, 0, 1, 0, 8'h12, 8'h34, 8'h56));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 3'b111, 0, 0, 0, 0, 8'h12, 8'h34, 8'h56));
        // Range and BCD rejection in HOUR
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 3'b011, 1, 0, 0, 0, 8'h12, 8'h34, 8'h56));
        vecs.push_back(mk(0, 0, 1, 0, 8'h24, 3'b011, 1, 1, 0, 0, 8'h12, 8'h34, 8'h56));
        vecs.push_back(mk(0, 0, 1, 0, 8'h1A, 3'b011, 1, 1, 0, 0, 8'h12, 8'h34, 8'h56));
        vecs.push_back(mk(0, 0, 1, 0, 8'h23, 3'b110, 1, 0, 0, 0, 8'h23, 8'h34, 8'h56));
        // Cancel beats enter in MIN; enter in IDLE ignored
        vecs.push_back(mk(0, 0, 1, 1, 8'h10, 3'b111, 0, 0, 0, 0, 8'h23, 8'h34, 8'h56));
        vecs.push_back(mk(0, 0, 1, 0, 8'h45, 3'b111, 0, 0, 0, 0, 8'h23, 8'h34, 8'h56));
        // Alarm target lock, plus MIN/SEC rejections
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 3'b011, 1, 0, 0, 1, 8'h23, 8'h34, 8'h56));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 3'b110, 1, 0, 0, 1, 8'h00, 8'h34, 8'h56));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 3'b110, 1, 0, 0, 1, 8'h00, 8'h34, 8'h56));
        vecs.push_back(mk(0, 0, 1, 0, 8'hA0, 3'b110, 1, 1, 0, 1, 8'h00, 8'h34, 8'h56));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 3'b101, 1, 0, 0, 1, 8'h00, 8'h00, 8'h56));
        vecs.push_back(mk(0, 0, 1, 0, 8'h60, 3'b101, 1, 1, 0, 1, 8'h00, 8'h00, 8'h56));
        vecs.push_back(mk(0, 0, 1, 0, 8'h59, 3'b111, 1, 0, 1, 1, 8'h00, 8'h00, 8'h59));
        // set_req during COMMIT is ignored
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 3'b111, 0, 0, 0, 1, 8'h00, 8'h00, 8'h59));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 3'b111, 0, 0, 0, 1, 8'h00, 8'h00, 8'h59));

        rst_n = 1'b0;
        set_req = 1'b0; target_sel = 1'b0; enter = 1'b0; cancel = 1'b0; time_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            set_req = vecs[i].set_req; target_sel = vecs[i].target_sel;
            enter = vecs[i].enter; cancel = vecs[i].cancel; time_in = vecs[i].time_in;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d field_sel", i), 32'(field_sel), 32'(e.field_sel));
            check($sformatf("v%0d busy", i),      32'(busy),      32'(e.busy));
            check($sformatf("v%0d err", i),       32'(err),       32'(e.err));
            check($sformatf("v%0d wr_en", i),     32'(wr_en),     32'(e.wr_en));
            check($sformatf("v%0d wr_alarm", i),  32'(wr_alarm),  32'(e.wr_alarm));
            check($sformatf("v%0d timeout", i),   32'(timeout),   32'h0);
            check($sformatf("v%0d hh", i),        32'(hh_out),    32'(e.hh));
            check($sformatf("v%0d mm", i),        32'(mm_out),    32'(e.mm));
            check($sformatf("v%0d ss", i),        32'(ss_out),    32'(e.ss));
        end
        check("scoreboard empty", 32'(sb.size()), 32'h0);

        // Async reset between edges while in SEC.
        drive(1, 1, 0, 0, 8'h00);
        drive(0, 0, 1, 0, 8'h12);
        drive(0, 0, 1, 0, 8'h34);
        check("pre-reset field_sel", 32'(field_sel), 32'h5);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 1, 0, 8'h56);
        check("post-reset wr_en", 32'(wr_en), 32'h0);
        check("post-reset field_sel", 32'(field_sel), 32'h7);
        drive(0, 0, 0, 0, 8'h00);
        check("post-reset wr_en 2", 32'(wr_en), 32'h0);

        // Session expiry, measured in rising edges after MIN is entered.
        drive(1, 0, 0, 0, 8'h00);
        drive(0, 0, 1, 0, 8'h12);
`ifdef TIME_SET_AUTO_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 0, 0, 8'h00);
            check($sformatf("idle k%0d timeout", k), 32'(timeout), (k == 8) ? 32'h1 : 32'h0);
            check($sformatf("idle k%0d field_sel", k), 32'(field_sel), (k == 8) ? 32'h7 : 32'h6);
        end
        drive(0, 0, 0, 0, 8'h00);
        check("expiry pulse width", 32'(timeout), 32'h0);
        check("expiry no write", 32'(wr_en), 32'h0);
        check("expiry idle", 32'(busy), 32'h0);

        drive(1, 0, 0, 0, 8'h00);
        drive(0, 0, 1, 0, 8'h12);
        for (int k = 1; k <= 14; k++) begin
            if (k == 6) drive(0, 0, 1, 0, 8'h99);
            else        drive(0, 0, 0, 0, 8'h00);
            check($sformatf("restart k%0d timeout", k), 32'(timeout), (k == 14) ? 32'h1 : 32'h0);
            check($sformatf("restart k%0d err", k), 32'(err), (k == 6) ? 32'h1 : 32'h0);
        end
        check("restart expiry idle", 32'(field_sel), 32'h7);
`else
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, 0, 0, 8'h00);
            check($sformatf("no-timeout k%0d", k), 32'(timeout), 32'h0);
        end
        check("no-timeout still MIN", 32'(field_sel), 32'h6);
        drive(0, 0, 0, 1, 8'h00);
        check("no-timeout cancel", 32'(busy), 32'h0);
`endif
        drive(0, 0, 0, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Sequences user entry of a BCD time (hour, then minute, then second) for either the running clock or the alarm.
- Validates each field as it is entered and stages the accepted values.
- Issues a single write pulse to the selected time register bank once all three fields are accepted.
- Sits between the debounced key logic and the clock/alarm register banks. Drives the field-select code consumed by the display and the validation path.

Parameters:
- TIMEOUT_CYCLES, 1000, idle cycles before an entry session is abandoned (used only with AUTO_TIMEOUT_EN).
- TW, 10, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- set_req  in  1  one-cycle pulse: start an entry session.
- target_sel  in  1  0 = clock, 1 = alarm; sampled on the accepted set_req.
- enter  in  1  one-cycle pulse: accept time_in for the current field.
- cancel  in  1  one-cycle pulse: abort the session.
- time_in  in  8  two-digit packed BCD value, tens in [7:4].
- busy  out  1  high in any state other than IDLE.
- field_sel  out  3  011 = hour, 110 = minute, 101 = second, 111 = none.
- err  out  1  one-cycle pulse on a rejected enter.
- wr_en  out  1  one-cycle commit pulse.
- wr_alarm  out  1  commit target; valid when wr_en is high.
- hh_out, mm_out, ss_out  out  8 each  staged BCD values; valid when wr_en is high, held otherwise.
- timeout  out  1  one-cycle pulse on session expiry.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - field_sel = 111.
  - busy, err, wr_en, wr_alarm, timeout = 0.
  - hh_out, mm_out, ss_out = 8'h00.
  - Timeout counter = 0.
- States: IDLE -> HOUR -> MIN -> SEC -> COMMIT -> IDLE.
- field_sel is decoded from the state register:
  - HOUR = 011, MIN = 110, SEC = 101.
  - IDLE and COMMIT = 111.
- IDLE:
  - set_req -> HOUR; latch target_sel into wr_alarm. Response is visible the next cycle.
  - enter and cancel are ignored.
- Validity of time_in:
  - Both nibbles must be <= 9 (BCD check).
  - HOUR: additionally time_in <= 8'h23.
  - MIN and SEC: additionally time_in <= 8'h59.
- Field states:
  - Valid enter: latch time_in into the matching staging register and advance one state.
  - Invalid enter: err = 1 for one cycle; state and staging registers unchanged.
- cancel has priority over enter in the same cycle.
  - cancel in HOUR, MIN or SEC -> IDLE.
  - No wr_en pulse; staging registers keep whatever was latched.
- set_req while busy is ignored; wr_alarm is not re-sampled.
- COMMIT lasts exactly one cycle:
  - wr_en = 1, hh_out/mm_out/ss_out stable.
  - Next state is IDLE unconditionally.
  - enter, cancel and set_req are ignored in COMMIT.
- Latency:
  - Final valid enter in SEC to wr_en high: 1 cycle.
  - Minimum session: set_req plus 3 enters, then 1 COMMIT cycle.
- err, wr_en and timeout are registered single-cycle pulses and never overlap.
- Reset asserted mid-session: returns to IDLE immediately; no write pulse.

Optional Feature:
- Macro: TIME_SET_AUTO_TIMEOUT_EN.
- Defined:
  - In HOUR, MIN and SEC, the counter increments each cycle.
  - It clears on state entry, on any enter (valid or not), and in IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no enter or cancel in that cycle: go to IDLE, pulse timeout for one cycle, no write.
  - cancel or enter in the same cycle takes priority over expiry.
- Not defined: counter logic is absent and timeout is tied to 0.

Decomposition:
- Shared package:
  - Field codes FIELD_HOUR = 3'b011, FIELD_MIN = 3'b110, FIELD_SEC = 3'b101, FIELD_NONE = 3'b111.
  - Limits MAX_HOUR_BCD = 8'h23, MAX_MINSEC_BCD = 8'h59.
  - State encoding constants.
- One sub-module: time_field_validator.
  - Combinational: (time_in, field_sel) -> valid.
  - Performs the BCD nibble check plus the range check.
  - Instantiated once, fed by the current field_sel.

Test Plan:
- Full clock entry:
  - Stimulus: set_req with target_sel = 0; enter with 8'h12, 8'h34, 8'h56.
  - Response: wr_en for one cycle, wr_alarm = 0, hh/mm/ss = 12/34/56, then field_sel = 111.
- Range and BCD rejection:
  - Stimulus: in HOUR, enter 8'h24, then 8'h1A, then 8'h23.
  - Response: err pulses twice; field_sel stays 011; the third enter advances to 110 with hh staged = 23.
- Cancel priority:
  - Stimulus: in MIN, assert enter (8'h10) and cancel in the same cycle.
  - Response: IDLE, busy = 0, no wr_en; mm_out unchanged.
- Alarm target lock:
  - Stimulus: set_req with target_sel = 1; toggle target_sel and pulse set_req mid-session; complete entry with 00/00/00.
  - Response: wr_en with wr_alarm = 1; field sequence not restarted.
- Async reset:
  - Stimulus: assert rst_n low between clock edges while in SEC.
  - Response: all outputs at reset values immediately; no wr_en after release.
- Timeout (macro defined, TIMEOUT_CYCLES = 8):
  - Stimulus: idle in MIN.
  - Response: timeout pulse on the 8th cycle after MIN entry, then IDLE, no write.
  - Stimulus: an enter at cycle 6.
  - Response: counter restarts; no timeout at cycle 8.
